// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream terminal front end for the VGA text
// generator. Decodes an ASCII stream into {attr, char} writes on the CPU port
// of the character RAM, tracks the cursor, and scrolls/clears the screen.
module text_console_writer #(
  parameter int         N_COL          = 80,
  parameter int         N_ROW          = 30,
  parameter logic [7:0] DEFAULT_ATTR   = 8'h0F,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter bit         VBLANK_ONLY    = 1'b0
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic [7:0]  s_attr,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        vBlank,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] SCROLL_RD = 3'd2;
  localparam logic [2:0] SCROLL_WR = 3'd3;
  localparam logic [2:0] CLEAR     = 3'd4;
  localparam logic [2:0] RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  localparam logic [15:0] LAST_CELL = 16'(N_COL * N_ROW - 1);
  localparam logic [15:0] LAST_COPY = 16'((N_ROW - 1) * N_COL - 1);
  localparam logic [15:0] ROW_SPAN  = 16'(N_COL);
  localparam logic [6:0]  LAST_COL  = 7'(N_COL - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(N_ROW - 1);
  localparam logic [15:0] BLANK     = {DEFAULT_ATTR, 8'h20};

  logic [2:0]  state, state_next;
  logic [15:0] idx, idx_next;
  logic [6:0]  col, col_next;
  logic [4:0]  row, row_next;
  logic [15:0] pend_addr, pend_addr_next;
  logic [15:0] pend_data, pend_data_next;
  logic        scroll_pend, scroll_pend_next;
  logic        we_q, oe_q, copy_q;
  logic        we_next, oe_next, copy_next;
  logic [15:0] addr_q, addr_next;
  logic [15:0] wdata_q, wdata_next;
  logic        vb_meta, vb_sync;
  logic        active, allowed, go;
  logic [15:0] cur_addr;

  // An access is "active" during the cycle its strobe is on the RAM port.
  assign active   = we_q | oe_q;
  assign allowed  = !VBLANK_ONLY || vb_sync;
  assign cur_addr = 16'(row) * ROW_SPAN + 16'(col);

  // Two-flop synchronizer for the generator's vertical blank.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_meta <= 1'b0;
      vb_sync <= 1'b0;
    end else begin
      vb_meta <= vBlank;
      vb_sync <= vb_meta;
    end
  end

  // Byte decode, cursor update and sequencing of write/scroll/clear passes.
  always_comb begin
    state_next       = state;
    idx_next         = idx;
    col_next         = col;
    row_next         = row;
    pend_addr_next   = pend_addr;
    pend_data_next   = pend_data;
    scroll_pend_next = scroll_pend;
    case (state)
      IDLE: begin
        if (s_valid) begin
          if (s_data >= 8'h20) begin
            pend_addr_next   = cur_addr;
            pend_data_next   = {s_attr, s_data};
            scroll_pend_next = 1'b0;
            state_next       = WRITE;
            if (col == LAST_COL) begin
              col_next = 7'd0;
              if (row == LAST_ROW) scroll_pend_next = 1'b1;
              else                 row_next = row + 5'd1;
            end else begin
              col_next = col + 7'd1;
            end
          end else begin
            case (s_data)
              8'h0D: col_next = 7'd0;
              8'h0A: begin
                if (row == LAST_ROW) begin
                  state_next = SCROLL_RD;
                  idx_next   = 16'd0;
                end else begin
                  row_next = row + 5'd1;
                end
              end
              8'h08: begin
                if (col != 7'd0) begin
                  col_next         = col - 7'd1;
                  pend_addr_next   = cur_addr - 16'd1;
                  pend_data_next   = BLANK;
                  scroll_pend_next = 1'b0;
                  state_next       = WRITE;
                end
              end
              8'h0C: begin
                col_next   = 7'd0;
                row_next   = 5'd0;
                state_next = CLEAR;
                idx_next   = 16'd0;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (active) begin
          scroll_pend_next = 1'b0;
          if (scroll_pend) begin
            state_next = SCROLL_RD;
            idx_next   = 16'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      SCROLL_RD: begin
        // Read data is only valid for one cycle, so the write must follow
        // immediately; if stalled, stay here and read again later.
        if (active && allowed) state_next = SCROLL_WR;
      end
      SCROLL_WR: begin
        if (active) begin
          idx_next   = idx + 16'd1;
          state_next = (idx == LAST_COPY) ? CLEAR : SCROLL_RD;
        end else begin
          state_next = SCROLL_RD;
        end
      end
      CLEAR: begin
        if (active) begin
          if (idx == LAST_CELL) state_next = IDLE;
          else                  idx_next   = idx + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next-cycle RAM strobes/address/data, derived from where the FSM goes.
  always_comb begin
    go         = allowed && (state_next != IDLE);
    we_next    = go && (state_next == WRITE || state_next == SCROLL_WR ||
                        state_next == CLEAR);
    oe_next    = go && (state_next == SCROLL_RD);
    copy_next  = go && (state_next == SCROLL_WR);
    addr_next  = addr_q;
    wdata_next = wdata_q;
    case (state_next)
      WRITE: begin
        addr_next  = pend_addr_next;
        wdata_next = pend_data_next;
      end
      SCROLL_RD: addr_next = idx_next + ROW_SPAN;
      SCROLL_WR: addr_next = idx_next;
      CLEAR: begin
        addr_next  = idx_next;
        wdata_next = BLANK;
      end
      default: ;
    endcase
  end

  // State, cursor and registered RAM-port outputs.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      idx         <= 16'd0;
      col         <= 7'd0;
      row         <= 5'd0;
      pend_addr   <= 16'd0;
      pend_data   <= 16'd0;
      scroll_pend <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      copy_q      <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      col         <= col_next;
      row         <= row_next;
      pend_addr   <= pend_addr_next;
      pend_data   <= pend_data_next;
      scroll_pend <= scroll_pend_next;
      we_q        <= we_next;
      oe_q        <= oe_next;
      copy_q      <= copy_next;
      addr_q      <= addr_next;
      wdata_q     <= wdata_next;
    end
  end

  // During a copy write the word read last cycle goes straight back into the RAM.
  assign ram_wdata  = copy_q ? ram_rdata : wdata_q;
  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_oe     = oe_q;
  assign s_ready    = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cursor_col = col;
  assign cursor_row = row;

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Byte-stream terminal front end for the VGA text generator. Accepts ASCII bytes over a valid/ready handshake, tracks a cursor, and writes `{attribute, char}` words into the character RAM through the CPU-side port (`cpu_addr`/`cpu_we`/`cpu_oe`/`cpu_dataIn`/`cpu_dataOut`). It also handles CR, LF, backspace, form-feed and wrap, and scrolls by row-copy through read-then-write cycles. It is the writer on the other side of the character RAM that the video pipeline reads.

## Interface
- `N_COL`, 80, text columns; must match the generator.
- `N_ROW`, 30, text rows; must match the generator.
- `DEFAULT_ATTR`, 8'h0F, attribute used for cleared and blanked cells.
- `CLEAR_ON_RESET`, 1, clear the whole screen after reset before accepting bytes.
- `VBLANK_ONLY`, 0, when 1 RAM accesses are issued only while synchronized vBlank is high.

Ports:
- `cpu_clk` in 1: single clock, the same clock as the character RAM CPU port.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_data` in 8: input byte.
- `s_attr` in 8: attribute for printable bytes, sampled with `s_data`.
- `s_valid` in 1: byte valid.
- `s_ready` out 1: block can accept a byte.
- `vBlank` in 1: asynchronous vertical blank from the generator.
- `ram_addr` out 16: cell address, zero-extended, to `cpu_addr`.
- `ram_we` out 1: write strobe, to `cpu_we`.
- `ram_oe` out 1: read strobe, to `cpu_oe`.
- `ram_wdata` out 16: `{attr, char}`, to `cpu_dataIn`.
- `ram_rdata` in 16: from `cpu_dataOut`; valid the cycle after `ram_oe` is sampled.
- `cursor_col` out 7: current column, 0..N_COL-1.
- `cursor_row` out 5: current row, 0..N_ROW-1.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Cell address = `cursor_row*N_COL + cursor_col`. `N_COL*N_ROW` must fit in 16 bits.
- A byte is accepted on a cycle where `s_valid && s_ready`. `s_ready = (state==IDLE)`.
- Byte decoding:
  - 0x20–0xFF (printable): write `{s_attr, s_data}` at the cursor, then col+1. If col reaches N_COL: col=0 and perform a newline.
  - 0x0D (CR): col=0. No RAM access.
  - 0x0A (LF): newline.
  - 0x08 (BS): if col>0, col-1, then write `{DEFAULT_ATTR, 8'h20}` at the new cursor. At col=0 it is a no-op.
  - 0x0C (FF): clear the screen, then cursor=(0,0).
  - Other 0x00–0x1F: consumed and ignored.
- Newline: if row<N_ROW-1, row+1. Otherwise scroll; row stays N_ROW-1.
- States:
  - IDLE: waits for an accepted byte.
  - WRITE: issues a single RAM write.
  - SCROLL_RD: addr=i+N_COL, oe=1.
  - SCROLL_WR: addr=i, we=1, wdata=`ram_rdata`; i+1. After i=(N_ROW-1)*N_COL-1, go to CLEAR over the last row only.
  - CLEAR: writes `{DEFAULT_ATTR, 8'h20}` at successive addresses over its range, one per cycle, then goes to IDLE.
- Transitions:
  - Printable byte: IDLE → WRITE → IDLE, or WRITE → SCROLL_RD when the wrap occurs on the last row.
  - LF on the last row: IDLE → SCROLL_RD.
  - FF: IDLE → CLEAR (full screen, 0..N_COL*N_ROW-1).
- vBlank handling:
  - `vBlank` passes through a 2-flop synchronizer.
  - When VBLANK_ONLY=1 and synchronized vBlank is low, the FSM holds state with `ram_we=ram_oe=0`.
  - A stall between SCROLL_RD and SCROLL_WR re-issues the read before the write.
- Cursor outputs update in the cycle the byte is accepted. A scroll or clear does not move the cursor, except FF, which homes it at acceptance.

## Timing
- On reset:
  - `ram_we=0`, `ram_oe=0`, `ram_addr=0`, `ram_wdata=0`, cursor=(0,0), synchronizer flops=0.
  - State = CLEAR (full screen) if CLEAR_ON_RESET, else IDLE.
  - `s_ready`/`busy` follow the state.
- All RAM outputs are registered. A byte accepted at cycle T produces `ram_we=1` at T+1 (printable/BS), and `s_ready=1` again at T+2.
- Scroll cost: 2·(N_ROW-1)·N_COL + N_COL cycles without stalls (4720 at 80×30).
- Full clear: N_COL·N_ROW cycles (2400).
- Asserting `rst_n` low mid-scroll or mid-clear aborts immediately; the outputs above are forced asynchronously.
- `ram_we` and `ram_oe` are never high in the same cycle.

## Test plan
- Reset with CLEAR_ON_RESET=1 → 2400 consecutive writes of 0x0F20 to addresses 0..2399, `s_ready` low throughout, then `s_ready=1` and cursor (0,0).
- Send 'A' with s_attr=0x1E → one cycle later `ram_addr=0`, `ram_wdata=0x1E41`, `ram_we=1`; `cursor_col=1`. Then send 0x08 → write 0x0F20 at addr 0, `cursor_col=0`. A second 0x08 → no write.
- Send 80 printable bytes on row 0 → last write at addr 79, cursor (0,1). Send 0x0D → col 0, no RAM access.
- Preload addr 80 with 0x0242 and set cursor row to 29; send 0x0A → addr 0 written with 0x0242, addresses 2320..2399 written with 0x0F20, 4720 busy cycles, cursor row stays 29.
- VBLANK_ONLY=1 with vBlank held low → byte accepted but no `ram_we`. Raise vBlank → the write occurs 3 cycles later.
- Pull `rst_n` low during a scroll → `ram_we`/`ram_oe` drop immediately. Release → the full clear restarts from addr 0.
